// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, widths and
// the registered-output decode used by the FSM output process.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Control outputs that are a pure function of the FSM state.
  typedef struct packed {
    logic pll_rst;
    logic sys_rst_n;
    logic pll_ready;
    logic lock_fail;
  } out_t;

  // Values held while rst_n is asserted: PLL in reset, system in reset.
  localparam out_t OUT_RESET = '{pll_rst: 1'b1, sys_rst_n: 1'b0, pll_ready: 1'b0, lock_fail: 1'b0};

  // Map a state to its control outputs; only RUN lets the system out of reset.
  function automatic out_t decode_outputs(input state_e s);
    out_t o;
    o = OUT_RESET;
    case (s)
      ST_WAIT_LOCK, ST_STABLE: o.pll_rst = 1'b0;
      ST_RUN: begin
        o.pll_rst   = 1'b0;
        o.sys_rst_n = 1'b1;
        o.pll_ready = 1'b1;
      end
      ST_FAIL: o.lock_fail = 1'b1;
      default: o = OUT_RESET;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the lock sequencer and its surroundings (PLL instance,
// software relock control, downstream reset consumers).
interface pll_lock_sequencer_if;
  import pll_ctrl_pkg::*;

  // Handshake: there is no valid/ready pair here. relock_req is a single-cycle
  // request sampled on every clk edge, with no acknowledge; pll_locked is a
  // raw asynchronous level. All outputs are registered levels that change
  // only on clk edges or on async reset.
  logic                pll_locked;
  logic                relock_req;
  logic                pll_rst;
  logic                sys_rst_n;
  logic                pll_ready;
  logic                lock_fail;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [STATE_W-1:0]  state_dbg;

  // Sequencer side.
  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, pll_ready, lock_fail, retry_cnt, state_dbg
  );

  // Environment side: PLL status and software control.
  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, pll_ready, lock_fail, retry_cnt, state_dbg
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous levels; resets to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL reset, waits for lock, qualifies it as
// stable, then releases the system reset. Loss of lock or a relock request
// replays the sequence; repeated lock timeouts end in a sticky failure.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_lock_sequencer_if.master  ctl
);

  // Terminal counts: the counter starts at 0 on state entry, so a phase of N
  // cycles ends when the counter shows N-1.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               restart;
  out_t               out_q, out_d;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ctl.pll_locked),
    .q_o   (lock_s)
  );

  // State, shared cycle counter, retry count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= OUT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  // Saturating increment so the retry count can never wrap.
  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

  // Next state, retry bookkeeping and counter control.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    restart = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (ctl.relock_req)         restart = 1'b1;
        else if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock is checked before the timeout so a lock arriving on the last
        // cycle still counts as success.
        if (ctl.relock_req)        state_d = ST_PLL_RST;
        else if (lock_s)           state_d = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
        end
      end
      ST_STABLE: begin
        if (ctl.relock_req)        state_d = ST_PLL_RST;
        else if (!lock_s)          state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (ctl.relock_req || !lock_s) state_d = ST_PLL_RST;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_PLL_RST;
    endcase

    // Cleared on every entry (including a relock restart within PLL_RST) and
    // parked at zero in RUN/FAIL where nothing is being timed.
    if ((state_d != state_q) || restart || (state_d == ST_RUN) || (state_d == ST_FAIL))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  // Outputs decoded from the next state so they change together with state_q.
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  assign ctl.pll_rst   = out_q.pll_rst;
  assign ctl.sys_rst_n = out_q.sys_rst_n;
  assign ctl.pll_ready = out_q.pll_ready;
  assign ctl.lock_fail = out_q.lock_fail;
  assign ctl.retry_cnt = retry_q;
  assign ctl.state_dbg = state_q;

endmodule
